// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: fetch sequencer state encoding, NOP word and alignment helper.
package pc_fetch_pkg;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_VALID = 3'd3,
    S_HALT  = 3'd4
  } fetch_state_t;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;
  function automatic logic is_aligned(input logic [31:0] a);
    return a[1:0] == 2'b00;
  endfunction
endpackage

// File: rtl/pc_fetch_pc_reg.sv
// pc_reg: 32-bit program counter with load enable, async reset to RESET_PC.
module pc_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic [31:0] i_d,
  output logic [31:0] o_q
);
  logic [31:0] r_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_q <= RESET_PC;
    else     r_q <= i_load ? i_d : r_q;
  assign o_q = r_q;
endmodule

// File: rtl/pc_fetch.sv
// pc_fetch: PC register and req/gnt/rvalid instruction-fetch sequencer.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = INST_NOP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] npc,
  input  logic        commit,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        misalign,
  output logic [31:0] instret
);
  fetch_state_t r_state;
  logic [31:0]  r_inst;
  logic [31:0]  r_instret;
  logic         r_misalign;
  logic         w_in_valid;
  logic         w_accept;
  logic         w_fault;
  logic         w_take;
  assign w_in_valid = r_state == S_VALID;
  assign w_accept   = w_in_valid & commit & is_aligned(npc);
  assign w_fault    = w_in_valid & commit & ~is_aligned(npc);
  // Data is only taken from a granted request or while waiting on one.
  assign w_take     = ((r_state == S_REQ) & imem_gnt & imem_rvalid) |
                      ((r_state == S_WAIT) & imem_rvalid);
  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_accept),
    .i_d    (npc),
    .o_q    (pc)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state    <= S_IDLE;
      r_inst     <= NOP_INST;
      r_misalign <= 1'b0;
      r_instret  <= '0;
    end else begin
      r_inst     <= w_take ? imem_rdata : r_inst;
      r_misalign <= r_misalign | w_fault;
      r_instret  <= r_instret + 32'(w_accept);
      case (r_state)
        S_IDLE:  r_state <= S_REQ;
        S_REQ:   r_state <= imem_gnt ? (imem_rvalid ? S_VALID : S_WAIT) : S_REQ;
        S_WAIT:  r_state <= imem_rvalid ? S_VALID : S_WAIT;
        S_VALID: r_state <= commit ? (is_aligned(npc) ? S_REQ : S_HALT) : S_VALID;
        default: r_state <= S_HALT;
      endcase
    end
  assign imem_req   = r_state == S_REQ;
  assign inst_valid = w_in_valid;
  assign imem_addr  = pc;
  assign inst       = r_inst;
  assign misalign   = r_misalign;
  assign instret    = r_instret;
endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed vector table, corner sequences and randomized memory-model run for pc_fetch.
module tb_pc_fetch;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] npc = '0;
  logic        commit = 1'b0;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] pc, inst, imem_addr, instret;
  logic        inst_valid, imem_req, misalign;
  int n_cmp = 0;
  int n_bad = 0;
  localparam logic [31:0] NOP = 32'h0000_0013;

  pc_fetch #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) dut (
    .clk         (clk),
    .rst         (rst),
    .npc         (npc),
    .commit      (commit),
    .pc          (pc),
    .inst        (inst),
    .inst_valid  (inst_valid),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .misalign    (misalign),
    .instret     (instret)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    int          gd;
    int          rd;
    logic [31:0] word;
    logic [31:0] npc;
    logic [31:0] exp_pc;
    logic [31:0] exp_ret;
    logic        exp_mis;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pc"}, pc, 32'h0);
    chk({tag, "_inst"}, inst, NOP);
    chk({tag, "_valid"}, inst_valid, 0);
    chk({tag, "_req"}, imem_req, 0);
    chk({tag, "_mis"}, misalign, 0);
    chk({tag, "_instret"}, instret, 0);
  endtask

  task automatic wait_req;
    for (int i = 0; i < 8 && !imem_req; i++) tick;
    chk("req_seen", imem_req, 1);
  endtask

  // Fetch one word: gd cycles without grant, then rvalid rd cycles after grant.
  // Junk commits and stray rvalids are driven throughout and must be ignored.
  task automatic do_fetch(input int gd, input int rd, input logic [31:0] word,
                          input logic [31:0] exp_pc, input logic [31:0] prev);
    wait_req;
    chk("fetch_addr", imem_addr, exp_pc);
    commit = 1'b1;
    npc = 32'hDEAD_0000;
    for (int i = 0; i < gd; i++) begin
      imem_gnt = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata = ~word;
      tick;
      chk("nognt_req", imem_req, 1);
      chk("nognt_addr", imem_addr, exp_pc);
      chk("nognt_inst", inst, prev);
    end
    imem_gnt = 1'b1;
    imem_rvalid = (rd == 0);
    imem_rdata = (rd == 0) ? word : ~word;
    tick;
    imem_gnt = 1'b0;
    for (int i = 0; i < rd; i++) begin
      chk("wait_valid", inst_valid, 0);
      chk("wait_req", imem_req, 0);
      imem_rvalid = (i == rd - 1);
      imem_rdata = word;
      tick;
    end
    imem_rvalid = 1'b0;
    commit = 1'b0;
    chk("fetch_valid", inst_valid, 1);
    chk("fetch_inst", inst, word);
    chk("fetch_pc", pc, exp_pc);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  vec_t v[5];
  logic [31:0] cur_pc, prev, ret_before;
  logic [31:0] exp_pc, exp_ret, exp_inst, pend_addr;
  logic exp_valid, pending;

  initial begin
    v[0] = '{0, 0, 32'h0050_0093, 32'h0000_0100, 32'h0000_0100, 32'd1, 1'b0};
    v[1] = '{3, 2, 32'h00A0_0113, 32'h0000_0100, 32'h0000_0100, 32'd2, 1'b0};
    v[2] = '{1, 0, 32'h0020_81B3, 32'h0000_0204, 32'h0000_0204, 32'd3, 1'b0};
    v[3] = '{0, 1, 32'h4030_8233, 32'h0000_0300, 32'h0000_0300, 32'd4, 1'b0};
    v[4] = '{2, 0, 32'h0000_0063, 32'h0000_0102, 32'h0000_0300, 32'd4, 1'b1};
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_reset("rst");
    rst = 1'b0;
    tick;
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, 32'h0);
    cur_pc = 32'h0;
    prev = NOP;
    for (int k = 0; k < 5; k++) begin
      do_fetch(v[k].gd, v[k].rd, v[k].word, cur_pc, prev);
      prev = v[k].word;
      npc = v[k].npc;
      commit = 1'b1;
      tick;
      commit = 1'b0;
      chk("vec_pc", pc, v[k].exp_pc);
      chk("vec_instret", instret, v[k].exp_ret);
      chk("vec_mis", misalign, {31'b0, v[k].exp_mis});
      if (!v[k].exp_mis) begin
        chk("vec_req", imem_req, 1);
        chk("vec_addr", imem_addr, v[k].exp_pc);
      end else begin
        chk("halt_req", imem_req, 0);
        chk("halt_valid", inst_valid, 0);
      end
      cur_pc = v[k].exp_pc;
    end
    for (int i = 0; i < 4; i++) begin
      imem_gnt = 1'b1;
      imem_rvalid = 1'b1;
      commit = 1'b1;
      npc = 32'h0000_0400;
      tick;
      chk("halt_hold_req", imem_req, 0);
      chk("halt_hold_valid", inst_valid, 0);
      chk("halt_hold_pc", pc, 32'h0000_0300);
      chk("halt_hold_ret", instret, 32'd4);
    end
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    commit = 1'b0;
    // reset escapes halt, then reset again while a grant is outstanding
    rst = 1'b1;
    #1 chk_reset("rst_halt");
    @(negedge clk);
    rst = 1'b0;
    tick;
    chk("re_req", imem_req, 1);
    imem_gnt = 1'b1;
    tick;
    imem_gnt = 1'b0;
    chk("re_wait_req", imem_req, 0);
    chk("re_wait_valid", inst_valid, 0);
    rst = 1'b1;
    #1 chk_reset("rst_wait");
    @(negedge clk);
    rst = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    tick;
    chk("stale_idle_inst", inst, NOP);
    chk("stale_idle_valid", inst_valid, 0);
    chk("stale_idle_req", imem_req, 1);
    tick;
    chk("stale_req_inst", inst, NOP);
    chk("stale_req_valid", inst_valid, 0);
    chk("stale_req_pc", pc, 32'h0);
    imem_rvalid = 1'b0;
    // instret wrap
    do_fetch(0, 0, 32'h0011_2233, 32'h0, NOP);
    force dut.r_instret = 32'hFFFF_FFFF;
    tick;
    release dut.r_instret;
    chk("preload", instret, 32'hFFFF_FFFF);
    npc = 32'h0000_0004;
    commit = 1'b1;
    tick;
    commit = 1'b0;
    chk("wrap_instret", instret, 32'h0);
    chk("wrap_pc", pc, 32'h4);
    do_fetch(0, 2, 32'h0044_5566, 32'h4, 32'h0011_2233);
    chk("wait_commit_ignored", instret, 32'h0);
    // randomized run against a transaction-level memory/core model
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tick;
    exp_pc = 32'h0;
    exp_ret = 32'h0;
    exp_valid = 1'b0;
    pending = 1'b0;
    exp_inst = NOP;
    pend_addr = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      chk("rnd_valid", inst_valid, exp_valid);
      chk("rnd_req", imem_req, !exp_valid && !pending);
      chk("rnd_pc", pc, exp_pc);
      chk("rnd_instret", instret, exp_ret);
      if (exp_valid) chk("rnd_inst", inst, exp_inst);
      if (imem_req) chk("rnd_addr", imem_addr, exp_pc);
      commit = ($urandom_range(0, 2) == 0);
      npc = {22'b0, 8'($urandom), 2'b00};
      if (exp_valid && commit) begin
        exp_pc = npc;
        exp_ret = exp_ret + 1;
        exp_valid = 1'b0;
      end
      imem_gnt = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata = $urandom;
      if (pending) begin
        imem_rvalid = ($urandom_range(0, 2) == 0);
        if (imem_rvalid) begin
          imem_rdata = mem_word(pend_addr);
          exp_inst = imem_rdata;
          exp_valid = 1'b1;
          pending = 1'b0;
        end
      end else if (imem_req) begin
        imem_gnt = $urandom_range(0, 1) == 1;
        imem_rvalid = $urandom_range(0, 1) == 1;
        if (imem_gnt && imem_rvalid) begin
          imem_rdata = mem_word(imem_addr);
          exp_inst = imem_rdata;
          exp_valid = 1'b1;
        end else if (imem_gnt) begin
          pending = 1'b1;
          pend_addr = imem_addr;
        end
      end else begin
        imem_gnt = $urandom_range(0, 1) == 1;
        imem_rvalid = $urandom_range(0, 3) == 0;
      end
      tick;
    end
    chk("rnd_progress", exp_ret > 100, 1);
    chk("rnd_no_mis", misalign, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
